// File: rtl/demux16_dispatch.sv
// Single-outstanding 1-to-16 write dispatcher with a registered one-hot strobe.
// Define DISPATCH_TIMEOUT_EN to add the BUSY timeout counter with err/err_sel reporting.
module demux16_dispatch #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_sel,
    input  logic [WIDTH-1:0] req_data,
    output logic [15:0]      slv_valid,
    output logic [WIDTH-1:0] slv_data,
    input  logic [15:0]      slv_ack,
    output logic             done,
    output logic             err,
    output logic [3:0]       err_sel
);

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("demux16_dispatch: TIMEOUT must be at least 1");
    end

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [15:0]      valid_q, valid_d;
    logic             done_q, done_d;

`ifdef DISPATCH_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [3:0]    err_sel_q, err_sel_d;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        err_sel_d = err_sel_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                valid_d = '0;
                if (req_valid) begin
                    state_d = S_BUSY;
                    sel_d   = req_sel;
                    data_d  = req_data;
                    // Strobe is built from req_sel here so slv_valid comes straight off a flop.
                    valid_d = 16'b1 << req_sel;
`ifdef DISPATCH_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_BUSY: begin
                if (slv_ack[sel_q]) begin
                    state_d = S_IDLE;
                    valid_d = '0;
                    done_d  = 1'b1;
                end
`ifdef DISPATCH_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    valid_d   = '0;
                    err_d     = 1'b1;
                    err_sel_d = sel_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                valid_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            err_q     <= 1'b0;
            err_sel_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            err_sel_q <= err_sel_d;
        end
    end

    assign err     = err_q;
    assign err_sel = err_sel_q;
`else
    assign err     = 1'b0;
    assign err_sel = '0;
`endif

    assign req_ready = (state_q == S_IDLE);
    assign slv_valid = valid_q;
    assign slv_data  = data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_demux16_dispatch.sv
// Scoreboard bench for demux16_dispatch: completions are queued when acks are driven
// and matched against done/err pulses observed on the falling edge.
module tb_demux16_dispatch;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_sel;
    logic [WIDTH-1:0] req_data;
    logic [15:0]      slv_valid;
    logic [WIDTH-1:0] slv_data;
    logic [15:0]      slv_ack;
    logic             done;
    logic             err;
    logic [3:0]       err_sel;

    demux16_dispatch #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .req_data  (req_data),
        .slv_valid (slv_valid),
        .slv_data  (slv_data),
        .slv_ack   (slv_ack),
        .done      (done),
        .err       (err),
        .err_sel   (err_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             is_err;
        logic [3:0]       sel;
        logic [WIDTH-1:0] data;
        int unsigned      cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_err, input logic [3:0] sel, input logic [WIDTH-1:0] data,
                        input int unsigned at);
        exp_t e;
        e.is_err = is_err;
        e.sel    = sel;
        e.data   = data;
        e.cyc    = at;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset_n && (done || err)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_pulse", 64'({done, err}), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_kind", 64'({done, err}), e.is_err ? 64'd1 : 64'd2);
                chk("sb_cycle", 64'(cyc), 64'(e.cyc));
                chk("sb_data", 64'(slv_data), 64'(e.data));
                chk("sb_valid_clear", 64'(slv_valid), 64'd0);
                if (e.is_err) chk("sb_err_sel", 64'(err_sel), 64'(e.sel));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0]      mask;
        logic [3:0]       s;
        logic [WIDTH-1:0] d;
        int unsigned      n;

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_sel   = '0;
        req_data  = '0;
        slv_ack   = '0;
        repeat (3) tick();
        chk("rst_valid", 64'(slv_valid), 64'd0);
        chk("rst_data", 64'(slv_data), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_err_sel", 64'(err_sel), 64'd0);
        reset_n = 1'b1;
        tick();
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_valid_rel", 64'(slv_valid), 64'd0);

        // Basic: sel 5, ack sampled on the third edge after accept
        req_valid = 1'b1;
        req_sel   = 4'd5;
        req_data  = 32'hDEADBEEF;
        tick();
        req_valid = 1'b0;
        req_sel   = 4'($urandom);
        req_data  = $urandom;
        n = cyc;
        for (int i = 0; i < 3; i++) begin
            chk("basic_valid", 64'(slv_valid), 64'h0020);
            chk("basic_data", 64'(slv_data), 64'hDEADBEEF);
            chk("basic_ready", 64'(req_ready), 64'd0);
            chk("basic_done_low", 64'(done), 64'd0);
            if (i < 2) tick();
        end
        slv_ack = 16'h0020;
        push(1'b0, 4'd5, 32'hDEADBEEF, cyc + 1);
        tick();
        slv_ack = '0;
        chk("basic_done_cycle", 64'(cyc), 64'(n + 3));
        chk("basic_done", 64'(done), 64'd1);
        chk("basic_ready_back", 64'(req_ready), 64'd1);
        tick();
        chk("basic_done_one", 64'(done), 64'd0);
        chk("basic_data_hold", 64'(slv_data), 64'hDEADBEEF);

        // Acks on a non-selected slot are ignored
        req_valid = 1'b1;
        req_sel   = 4'd3;
        req_data  = 32'h0BAD_F00D;
        tick();
        req_valid = 1'b0;
        slv_ack   = 16'h0080;
        for (int i = 0; i < 4; i++) begin
            chk("wrong_valid", 64'(slv_valid), 64'h0008);
            chk("wrong_done_low", 64'(done), 64'd0);
            tick();
        end
        chk("wrong_valid_last", 64'(slv_valid), 64'h0008);
        slv_ack = 16'h0008;
        push(1'b0, 4'd3, 32'h0BAD_F00D, cyc + 1);
        tick();
        slv_ack = '0;
        chk("wrong_done", 64'(done), 64'd1);
        chk("wrong_err", 64'(err), 64'd0);
        tick();

`ifdef DISPATCH_TIMEOUT_EN
        req_valid = 1'b1;
        req_sel   = 4'd12;
        req_data  = 32'h1234_5678;
        tick();
        req_valid = 1'b0;
        push(1'b1, 4'd12, 32'h1234_5678, cyc + TIMEOUT);
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            chk("to_valid", 64'(slv_valid), 64'h1000);
            tick();
        end
        chk("to_err", 64'(err), 64'd1);
        chk("to_err_sel", 64'(err_sel), 64'd12);
        chk("to_ready", 64'(req_ready), 64'd1);
        chk("to_done", 64'(done), 64'd0);
        tick();
        chk("to_err_one", 64'(err), 64'd0);
        chk("to_err_sel_hold", 64'(err_sel), 64'd12);

        // Ack on the final allowed cycle beats the timeout
        req_valid = 1'b1;
        req_sel   = 4'd6;
        req_data  = 32'hCAFE_0006;
        tick();
        req_valid = 1'b0;
        repeat (TIMEOUT - 1) tick();
        chk("to_edge_valid", 64'(slv_valid), 64'h0040);
        slv_ack = 16'h0040;
        push(1'b0, 4'd6, 32'hCAFE_0006, cyc + 1);
        tick();
        slv_ack = '0;
        chk("to_edge_done", 64'(done), 64'd1);
        chk("to_edge_err", 64'(err), 64'd0);
        chk("to_edge_err_sel", 64'(err_sel), 64'd12);
        tick();
`else
        req_valid = 1'b1;
        req_sel   = 4'd12;
        req_data  = 32'h1234_5678;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            chk("noto_valid", 64'(slv_valid), 64'h1000);
            chk("noto_err", 64'(err), 64'd0);
            tick();
        end
        slv_ack = 16'h1000;
        push(1'b0, 4'd12, 32'h1234_5678, cyc + 1);
        tick();
        slv_ack = '0;
        chk("noto_done", 64'(done), 64'd1);
        chk("noto_err_sel", 64'(err_sel), 64'd0);
        tick();
`endif

        // Back-to-back with req_valid held: second accept lands on the done cycle
        req_valid = 1'b1;
        req_sel   = 4'd0;
        req_data  = 32'hAAAA_0000;
        slv_ack   = 16'h0001;
        tick();
        n = cyc;
        chk("b2b_valid0", 64'(slv_valid), 64'h0001);
        push(1'b0, 4'd0, 32'hAAAA_0000, cyc + 1);
        req_sel  = 4'd15;
        req_data = 32'hBBBB_000F;
        slv_ack  = 16'h8001;
        tick();
        chk("b2b_done0", 64'(done), 64'd1);
        chk("b2b_ready", 64'(req_ready), 64'd1);
        push(1'b0, 4'd15, 32'hBBBB_000F, n + 3);
        tick();
        req_valid = 1'b0;
        chk("b2b_valid15", 64'(slv_valid), 64'h8000);
        tick();
        slv_ack = '0;
        chk("b2b_done15", 64'(done), 64'd1);
        tick();

        // Random traffic with noise on non-selected ack lines
        for (int t = 0; t < 8; t++) begin
            s = 4'($urandom);
            d = $urandom;
            mask = 16'b1 << s;
            req_valid = 1'b1;
            req_sel   = s;
            req_data  = d;
            tick();
            req_valid = 1'b0;
            repeat ($urandom_range(1, 5)) begin
                chk("rnd_valid", 64'(slv_valid), 64'(mask));
                slv_ack = 16'($urandom) & ~mask;
                tick();
            end
            slv_ack = mask | (16'($urandom) & ~mask);
            push(1'b0, s, d, cyc + 1);
            tick();
            slv_ack = '0;
            chk("rnd_done", 64'(done), 64'd1);
        end
        tick();

        // Reset while BUSY drops the transaction without done/err
        req_valid = 1'b1;
        req_sel   = 4'd9;
        req_data  = 32'h9999_9999;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("mid_valid_pre", 64'(slv_valid), 64'h0200);
        reset_n = 1'b0;
        #1;
        chk("mid_valid_async", 64'(slv_valid), 64'd0);
        chk("mid_data_async", 64'(slv_data), 64'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) begin
            tick();
            chk("mid_done", 64'(done), 64'd0);
            chk("mid_err", 64'(err), 64'd0);
            chk("mid_ready", 64'(req_ready), 64'd1);
        end

        repeat (2) tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
